// File: rtl/sig_dump_monitor.sv
// sig_dump_monitor: snoops signature pointers and the end-of-test flag, then streams the
// signature region over a valid/ready channel while accumulating a CRC-32.
module sig_dump_monitor #(
    parameter int          ADDR_W         = 32,
    parameter int          FLAG_IDX       = 4,
    parameter int          BEGIN_IDX      = 2,
    parameter int          END_IDX        = 3,
    parameter logic [31:0] END_VALUE      = 32'h1,
    parameter int          TIMEOUT_CYCLES = 25000,
    parameter int          CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic [31:0]       snoop_wdata,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [31:0]       sig_data,
    output logic [ADDR_W-1:0] sig_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       crc,
    output logic [CNT_W-1:0]  word_count
);
    typedef enum logic [2:0] {IDLE, RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE, TMO} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] beg_r, end_r, ptr;
    logic [31:0]       tcnt, crc_r;
    logic [ADDR_W-3:0] widx;
    logic              arm, hit_beg, hit_end, flag_hit, tc_hit, empty;
    logic              unused_bits;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int i = 0; i < 32; i++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
        return r;
    endfunction

    assign widx        = snoop_addr[ADDR_W-1:2];
    assign arm         = state == IDLE || state == RUN;
    assign hit_beg     = snoop_we && widx == (ADDR_W-2)'(BEGIN_IDX);
    assign hit_end     = snoop_we && widx == (ADDR_W-2)'(END_IDX);
    assign flag_hit    = snoop_we && widx == (ADDR_W-2)'(FLAG_IDX) && snoop_wdata == END_VALUE;
    assign tc_hit      = TIMEOUT_CYCLES != 0 && tcnt == 32'(TIMEOUT_CYCLES - 1);
    assign empty       = ptr >= end_r;
    assign unused_bits = ^{snoop_addr[1:0], beg_r[1:0]};

    assign mem_rd_req  = state == DUMP_REQ && !empty;
    assign mem_rd_addr = ptr;
    assign sig_valid   = state == DUMP_OUT;
    assign busy        = state == RUN || state == DUMP_REQ || state == DUMP_WAIT || state == DUMP_OUT;
    assign done        = state == DONE;
    assign timeout     = state == TMO;
    assign crc         = ~crc_r;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? RUN : IDLE;
            RUN:       state_n = flag_hit ? DUMP_REQ : tc_hit ? TMO : RUN;
            DUMP_REQ:  state_n = empty ? DONE : DUMP_WAIT;
            DUMP_WAIT: state_n = mem_rd_valid ? DUMP_OUT : DUMP_WAIT;
            DUMP_OUT:  state_n = sig_ready ? DUMP_REQ : DUMP_OUT;
            default:   state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beg_r      <= '0;
            end_r      <= '0;
            ptr        <= '0;
            tcnt       <= '0;
            crc_r      <= 32'hFFFF_FFFF;
            sig_data   <= '0;
            sig_addr   <= '0;
            word_count <= '0;
        end else begin
            state <= state_n;
            if (arm && hit_beg) beg_r <= ADDR_W'(snoop_wdata);
            if (arm && hit_end) end_r <= ADDR_W'(snoop_wdata);
            if (state == RUN) tcnt <= tcnt + 32'd1;
            // The begin pointer is word-aligned once, on entry to the dump
            if (state == RUN && state_n == DUMP_REQ) ptr <= {beg_r[ADDR_W-1:2], 2'b00};
            if (state == DUMP_WAIT && mem_rd_valid) begin
                sig_data <= mem_rd_data;
                sig_addr <= ptr;
            end
            if (state == DUMP_OUT && sig_ready) begin
                crc_r      <= crc_step(crc_r, sig_data);
                word_count <= word_count + 1'b1;
                ptr        <= ptr + ADDR_W'(4);
            end
        end
    end
endmodule

// File: tb/tb_sig_dump_monitor.sv
// tb_sig_dump_monitor: directed bench for sig_dump_monitor with a 1-cycle-latency memory
// model and a byte-serial CRC-32 reference.
module tb_sig_dump_monitor;
    logic        clk = 0, rst_n = 0, start = 0, snoop_we = 0;
    logic [31:0] snoop_addr = 0, snoop_wdata = 0;
    logic        mem_rd_req, mem_rd_valid = 0;
    logic [31:0] mem_rd_addr, mem_rd_data = 0;
    logic        sig_valid, sig_ready = 0;
    logic [31:0] sig_data, sig_addr;
    logic        busy, done, timeout;
    logic [31:0] crc;
    logic [15:0] word_count;

    int          checks = 0, failures = 0, rq_cnt = 0;
    logic [31:0] mem [0:255];
    logic [31:0] q_addr[$], q_data[$];
    logic [31:0] d0, a0, mc;

    sig_dump_monitor #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .snoop_we(snoop_we), .snoop_addr(snoop_addr), .snoop_wdata(snoop_wdata),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_data(sig_data), .sig_addr(sig_addr),
        .busy(busy), .done(done), .timeout(timeout), .crc(crc), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after each request; transfers are logged as they happen
    always @(posedge clk) begin
        mem_rd_valid <= mem_rd_req;
        if (mem_rd_req) mem_rd_data <= mem[mem_rd_addr[9:2]];
        if (!rst_n) begin
            rq_cnt <= 0;
            q_addr.delete();
            q_data.delete();
        end else begin
            if (mem_rd_req) rq_cnt <= rq_cnt + 1;
            if (sig_valid && sig_ready) begin
                q_addr.push_back(sig_addr);
                q_data.push_back(sig_data);
            end
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 4; k++) r = crc_byte(r, w[8*k +: 8]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; snoop_we = 0; sig_ready = 1;
        tick(2);
        rst_n = 1;
    endtask

    task automatic pulse_start();
        start = 1; tick(1); start = 0;
    endtask

    task automatic snoop(input logic [31:0] a, input logic [31:0] d);
        snoop_we = 1; snoop_addr = a; snoop_wdata = d;
        tick(1);
        snoop_we = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && !done; i++) tick(1);
        chk(tag, {31'b0, done}, 32'h1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && !sig_valid; i++) tick(1);
        chk(tag, {31'b0, sig_valid}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h80] = 32'h11; mem[8'h81] = 32'h22; mem[8'h82] = 32'h33; mem[8'h83] = 32'h44;
        mem[8'h41] = 32'hA5A5_0001;
        mem[8'h60] = 32'hDEAD_BEEF;

        // Reset state
        tick(2);
        chk("rst_outs", {mem_rd_req, sig_valid, busy, done, timeout}, 32'h0);
        chk("rst_crc", crc, 32'h0);
        chk("rst_wc", {16'h0, word_count}, 32'h0);
        chk("rst_sig_data", sig_data, 32'h0);

        // Single zero word
        do_reset();
        pulse_start();
        chk("t1_busy", {31'b0, busy}, 32'h1);
        snoop(32'h8, 32'h100); snoop(32'hC, 32'h104); snoop(32'h10, 32'h1);
        wait_done("t1_done");
        chk("t1_wc", {16'h0, word_count}, 32'h1);
        chk("t1_crc", crc, 32'h2144_DF1C);
        chk("t1_addr", q_addr[0], 32'h100);
        chk("t1_data", q_data[0], 32'h0);
        chk("t1_busy_end", {31'b0, busy}, 32'h0);

        // Four words with a 5-cycle stall on the second
        do_reset();
        pulse_start();
        snoop(32'h8, 32'h200); snoop(32'hC, 32'h210); snoop(32'h10, 32'h1);
        for (int i = 0; i < 100 && word_count != 16'd1; i++) tick(1);
        chk("t2_first", {16'h0, word_count}, 32'h1);
        sig_ready = 0;
        wait_valid("t2_valid2");
        d0 = sig_data; a0 = sig_addr;
        chk("t2_stall_addr", a0, 32'h204);
        chk("t2_stall_data", d0, 32'h22);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t2_hold_data", sig_data, d0);
            chk("t2_hold_addr", sig_addr, a0);
            chk("t2_hold_valid", {31'b0, sig_valid}, 32'h1);
            chk("t2_hold_wc", {16'h0, word_count}, 32'h1);
        end
        sig_ready = 1;
        wait_done("t2_done");
        chk("t2_nwords", q_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", q_addr[i], 32'h200 + 32'(4 * i));
            chk("t2_data", q_data[i], 32'h11 * 32'(i + 1));
        end
        chk("t2_wc", {16'h0, word_count}, 32'h4);
        chk("t2_reqs", rq_cnt, 32'd4);
        mc = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) mc = crc_word(mc, 32'h11 * 32'(i + 1));
        chk("t2_crc", crc, ~mc);

        // Empty region
        do_reset();
        pulse_start();
        snoop(32'h8, 32'h300); snoop(32'hC, 32'h300); snoop(32'h10, 32'h1);
        chk("t3_req", {31'b0, mem_rd_req}, 32'h0);
        chk("t3_done_early", {31'b0, done}, 32'h0);
        tick(1);
        chk("t3_done", {31'b0, done}, 32'h1);
        chk("t3_crc", crc, 32'h0);
        chk("t3_wc", {16'h0, word_count}, 32'h0);
        chk("t3_reqs", rq_cnt, 32'd0);

        // Timeout after 10 RUN cycles
        do_reset();
        pulse_start();
        tick(9);
        chk("t4_not_yet", {30'b0, timeout, busy}, 32'h1);
        tick(1);
        chk("t4_timeout", {30'b0, timeout, busy}, 32'h2);
        snoop(32'h10, 32'h1);
        tick(3);
        chk("t4_sticky", {30'b0, timeout, done}, 32'h2);

        // Flag on the terminal-count cycle wins
        do_reset();
        pulse_start();
        snoop(32'h8, 32'h100); snoop(32'hC, 32'h104);
        tick(7);
        snoop(32'h10, 32'h1);
        chk("t4b_no_tmo", {31'b0, timeout}, 32'h0);
        wait_done("t4b_done");
        chk("t4b_wc", {16'h0, word_count}, 32'h1);
        chk("t4b_tmo_end", {31'b0, timeout}, 32'h0);

        // Wrong flag value ignored; pointer writes after the flag ignored
        do_reset();
        pulse_start();
        snoop(32'h8, 32'h100); snoop(32'hC, 32'h108); snoop(32'h10, 32'h2);
        chk("t5_still_run", {29'b0, busy, mem_rd_req, done}, 32'h4);
        snoop(32'h10, 32'h1);
        snoop(32'h8, 32'h0); snoop(32'hC, 32'h400);
        wait_done("t5_done");
        chk("t5_wc", {16'h0, word_count}, 32'h2);
        chk("t5_addr0", q_addr[0], 32'h100);
        chk("t5_addr1", q_addr[1], 32'h104);
        chk("t5_data1", q_data[1], 32'hA5A5_0001);

        // Reset while a word is being offered
        do_reset();
        sig_ready = 0;
        pulse_start();
        snoop(32'h8, 32'h180); snoop(32'hC, 32'h184); snoop(32'h10, 32'h1);
        wait_valid("t6_valid");
        chk("t6_data", sig_data, 32'hDEAD_BEEF);
        rst_n = 0;
        tick(1);
        chk("t6_rst_outs", {mem_rd_req, sig_valid, busy, done, timeout}, 32'h0);
        chk("t6_rst_data", sig_data, 32'h0);
        chk("t6_rst_addr", sig_addr, 32'h0);
        chk("t6_rst_crc", crc, 32'h0);
        chk("t6_rst_wc", {16'h0, word_count}, 32'h0);
        rst_n = 1; sig_ready = 1;
        pulse_start();
        snoop(32'h8, 32'h180); snoop(32'hC, 32'h184); snoop(32'h10, 32'h1);
        wait_done("t6_done");
        chk("t6_wc", {16'h0, word_count}, 32'h1);
        chk("t6_addr", q_addr[0], 32'h180);
        chk("t6_crc", crc, ~crc_word(32'hFFFF_FFFF, 32'hDEAD_BEEF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sig_dump_monitor.md
Name: sig_dump_monitor

Overview:
- Synthesizable successor to the simulation-only end-of-test signature dump; usable on FPGA.
- Snoops the data-RAM write bus and captures the begin/end signature pointers.
- Detects the end-of-test flag write, then walks the signature region through a memory read port.
- Streams each word out on a valid/ready channel, accumulates a CRC-32, and reports done, timeout and word count.

Parameters:
- ADDR_W, 32, byte-address width of the snoop and read ports.
- FLAG_IDX, 4, RAM word index of the end-of-test flag.
- BEGIN_IDX, 2, RAM word index holding the signature begin byte address.
- END_IDX, 3, RAM word index holding the signature end byte address (exclusive).
- END_VALUE, 32'h1, flag value that ends the test.
- TIMEOUT_CYCLES, 25000, cycles allowed in RUN before timeout; 0 disables the timeout.
- CNT_W, 16, width of word_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; IDLE->RUN; ignored in other states.
- snoop_we  in  1  RAM full-word write strobe.
- snoop_addr  in  ADDR_W  RAM write byte address.
- snoop_wdata  in  32  RAM write data.
- mem_rd_req  out  1  one-cycle read request.
- mem_rd_addr  out  ADDR_W  word-aligned read byte address.
- mem_rd_valid  in  1  read data valid, returned 1..N cycles after the request.
- mem_rd_data  in  32  read data.
- sig_valid  out  1  signature word available.
- sig_ready  in  1  consumer accepts the word.
- sig_data  out  32  signature word.
- sig_addr  out  ADDR_W  byte address of sig_data.
- busy  out  1  state is neither IDLE nor DONE nor TIMEOUT.
- done  out  1  sticky; dump complete.
- timeout  out  1  sticky; no end flag within TIMEOUT_CYCLES.
- crc  out  32  CRC-32 of dumped words; valid when done=1.
- word_count  out  CNT_W  number of words accepted on the sig channel.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - All outputs are 0, except the CRC register, which is 32'hFFFF_FFFF (so crc reads 0).
  - begin/end registers, timeout counter and word_count are 0.
  - Reset asserted mid-dump aborts immediately; no partial handshake is completed.
- Snoop decode:
  - Word index is snoop_addr[ADDR_W-1:2].
  - Byte lanes are not checked; only full-word writes are snooped.
  - The begin/end registers load only in IDLE and RUN and freeze after leaving RUN.
  - A write to FLAG_IDX with data==END_VALUE in RUN moves to DUMP_REQ on the next edge.
  - A flag write with any other value is ignored.
- Timeout:
  - The counter increments every RUN cycle.
  - When it reaches TIMEOUT_CYCLES, the next state is TIMEOUT: timeout=1, sticky until reset.
  - If the end flag and the terminal count occur in the same cycle, the flag wins.
- States: IDLE -> RUN -> DUMP_REQ -> DUMP_WAIT -> DUMP_OUT -> (DUMP_REQ | DONE); plus TIMEOUT.
- Entry to DUMP_REQ: ptr = {begin[ADDR_W-1:2],2'b00}.
- DUMP_REQ:
  - If ptr >= end (unsigned), go to DONE with zero words and crc=0.
  - Otherwise drive mem_rd_req=1 and mem_rd_addr=ptr for exactly one cycle, then go to DUMP_WAIT.
- DUMP_WAIT:
  - Wait for mem_rd_valid, with no bound.
  - Latch mem_rd_data into sig_data and ptr into sig_addr, then go to DUMP_OUT.
  - mem_rd_valid in any other state is ignored.
- DUMP_OUT:
  - sig_valid=1; sig_data and sig_addr are held stable until sig_valid&sig_ready.
  - sig_ready may be high before sig_valid; transfer occurs in the first cycle both are high.
  - On transfer: CRC updates over the 4 bytes little-endian; word_count+=1 (wraps at 2^CNT_W); ptr+=4; go to DUMP_REQ.
- Timing: minimum 3 cycles per word (req, 1-cycle read latency, out with ready already high).
- CRC-32/IEEE:
  - Reflected polynomial 32'hEDB8_8320, init 32'hFFFF_FFFF.
  - Output crc = ~reg.
  - Combinational 32-bit-per-cycle update.
- End address handling:
  - Non-aligned end: a word is dumped while ptr < end, so a partial last word is included.
  - Pointer arithmetic wraps modulo 2^ADDR_W; end==0 with begin!=0 is treated as an empty region.
- DONE and TIMEOUT are terminal until reset; start is ignored there.

Test Plan:
- Start; snoop begin=0x100, end=0x104, flag=1; read port returns 0x0000_0000 after 1 cycle, ready tied high -> one sig word (addr 0x100, data 0), done=1, word_count=1, crc=32'h2144_DF1C.
- begin=0x200, end=0x210; read data 0x11,0x22,0x33,0x44; sig_ready low for 5 cycles on the 2nd word -> sig_data/sig_addr stable throughout stall, addresses 0x200..0x20C in order, word_count=4, exactly 4 mem_rd_req pulses.
- begin=end=0x300 then flag=1 -> no mem_rd_req, done=1 two cycles after flag, crc=0, word_count=0.
- TIMEOUT_CYCLES=10, start, no flag -> timeout=1 after 10 RUN cycles, busy=0, later flag write ignored, done stays 0; second run with flag and terminal count in the same cycle -> dump proceeds, timeout=0.
- Flag write with data 0x2, then begin write after flag=1 -> 0x2 ignored; post-flag begin write does not change the dumped range.
- Reset asserted while in DUMP_OUT with sig_valid=1 -> next edge all outputs 0; after release, start re-arms normally.
